// File: rtl/vga_console_writer_pkg.sv
// Shared constants, control codes and FSM encoding for the console writer and text controller.
package vga_console_writer_pkg;

    localparam int CHARS_X = 80;
    localparam int CHARS_Y = 60;
    localparam int ADDR_W  = 13;
    localparam int CELLS   = CHARS_X * CHARS_Y;

    localparam logic [7:0] FILL_CHAR = 8'h20;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_FF     = 8'h0C;

    localparam logic [6:0] LAST_X = 7'(CHARS_X - 1);
    localparam logic [5:0] LAST_Y = 6'(CHARS_Y - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLR_ROW = 2'd1,
        ST_CLR_ALL = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_console_writer_if.sv
// CPU byte stream in, text RAM write port and cursor status out.
interface vga_console_writer_if;
    import vga_console_writer_pkg::*;

    logic              char_valid;
    logic [7:0]        char_in;
    logic              char_ready;
    logic              busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic [6:0]        cursor_x;
    logic [5:0]        cursor_y;

    modport master (
        output char_valid, char_in,
        input  char_ready, busy, ram_we, ram_addr, ram_data, cursor_x, cursor_y
    );

    modport slave (
        input  char_valid, char_in,
        output char_ready, busy, ram_we, ram_addr, ram_data, cursor_x, cursor_y
    );

endinterface

// File: rtl/vga_console_writer_cursor.sv
// Cursor x/y counters with a running row base address so no multiplier is needed.
// Latency: controls take effect on the next proc_clk edge.
// Backpressure: none; the caller asserts at most one control per cycle.
module vga_console_writer_cursor
    import vga_console_writer_pkg::*;
(
    input  logic              proc_clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              adv,
    input  logic              cr,
    input  logic              bs,
    input  logic              home,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic [ADDR_W-1:0] row_base,
    output logic [ADDR_W-1:0] next_row_base
);

    logic wrap_x;
    logic line_adv;

    assign wrap_x        = inc && (cursor_x == LAST_X);
    assign line_adv      = adv || wrap_x;
    assign next_row_base = (cursor_y == LAST_Y) ? '0 : row_base + ADDR_W'(CHARS_X);

    always_ff @(posedge proc_clk or posedge rst) begin
        if (rst) begin
            cursor_x <= '0;
            cursor_y <= '0;
            row_base <= '0;
        end else if (home) begin
            cursor_x <= '0;
            cursor_y <= '0;
            row_base <= '0;
        end else begin
            if (inc)
                cursor_x <= wrap_x ? '0 : cursor_x + 7'd1;
            else if (cr)
                cursor_x <= '0;
            else if (bs && (cursor_x != '0))
                cursor_x <= cursor_x - 7'd1;

            if (line_adv) begin
                cursor_y <= (cursor_y == LAST_Y) ? '0 : cursor_y + 6'd1;
                row_base <= next_row_base;
            end
        end
    end

endmodule

// File: rtl/vga_console_writer.sv
// Terminal front end: turns a CPU byte stream into text RAM writes and tracks the cursor.
// Latency: a byte's write appears one cycle after acceptance; row/screen clears run one cell per cycle.
// Backpressure: char_ready is low for the whole of any clear sequence; offered bytes wait.
module vga_console_writer
    import vga_console_writer_pkg::*;
(
    input  logic                 proc_clk,
    input  logic                 rst,
    vga_console_writer_if.slave  bus
);

    state_t            state, nxt_state;
    logic [ADDR_W-1:0] clr_cnt, nxt_cnt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              cur_inc, cur_adv, cur_cr, cur_bs, cur_home;
    logic [6:0]        cursor_x;
    logic [5:0]        cursor_y;
    logic [ADDR_W-1:0] row_base, next_row_base, cur_addr;

    vga_console_writer_cursor u_cursor (
        .proc_clk      (proc_clk),
        .rst           (rst),
        .inc           (cur_inc),
        .adv           (cur_adv),
        .cr            (cur_cr),
        .bs            (cur_bs),
        .home          (cur_home),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .row_base      (row_base),
        .next_row_base (next_row_base)
    );

    assign cur_addr     = row_base + ADDR_W'(cursor_x);
    assign bus.cursor_x = cursor_x;
    assign bus.cursor_y = cursor_y;

    always_ff @(posedge proc_clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLR_ALL;
            clr_cnt <= '0;
        end else begin
            state   <= nxt_state;
            clr_cnt <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = clr_cnt;
        wr_en     = 1'b0;
        wr_addr   = clr_cnt;
        wr_data   = FILL_CHAR;
        cur_inc   = 1'b0;
        cur_adv   = 1'b0;
        cur_cr    = 1'b0;
        cur_bs    = 1'b0;
        cur_home  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.char_valid) begin
                    if (is_printable(bus.char_in)) begin
                        wr_en   = 1'b1;
                        wr_addr = cur_addr;
                        wr_data = bus.char_in;
                        cur_inc = 1'b1;
                        if (cursor_x == LAST_X) begin
                            nxt_state = ST_CLR_ROW;
                            nxt_cnt   = '0;
                        end
                    end else begin
                        case (bus.char_in)
                            // LF has no character write, so the first clear cell goes out now.
                            CH_LF: begin
                                cur_adv   = 1'b1;
                                wr_en     = 1'b1;
                                wr_addr   = next_row_base;
                                nxt_state = ST_CLR_ROW;
                                nxt_cnt   = ADDR_W'(1);
                            end
                            CH_CR: cur_cr = 1'b1;
                            CH_BS: begin
                                if (cursor_x != '0) begin
                                    cur_bs  = 1'b1;
                                    wr_en   = 1'b1;
                                    wr_addr = cur_addr - ADDR_W'(1);
                                end
                            end
                            CH_FF: begin
                                cur_home  = 1'b1;
                                nxt_state = ST_CLR_ALL;
                                nxt_cnt   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLR_ROW: begin
                if (clr_cnt == ADDR_W'(CHARS_X)) begin
                    nxt_state = ST_IDLE;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = row_base + clr_cnt;
                    nxt_cnt = clr_cnt + ADDR_W'(1);
                end
            end
            ST_CLR_ALL: begin
                if (clr_cnt == ADDR_W'(CELLS)) begin
                    nxt_state = ST_IDLE;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = clr_cnt;
                    nxt_cnt = clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                nxt_state = ST_CLR_ALL;
                nxt_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.char_ready = (state == ST_IDLE);
        bus.busy       = (state != ST_IDLE);
    end

    always_ff @(posedge proc_clk or posedge rst) begin
        if (rst) begin
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
        end else begin
            bus.ram_we <= wr_en;
            if (wr_en) begin
                bus.ram_addr <= wr_addr;
                bus.ram_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed test of vga_console_writer: clears, printable writes, control codes, async reset.
module tb_vga_console_writer;
    import vga_console_writer_pkg::*;

    logic proc_clk = 1'b0;
    logic rst;
    always #5 proc_clk = ~proc_clk;

    vga_console_writer_if bus();

    vga_console_writer dut (
        .proc_clk (proc_clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check_val({tag, "_x"}, int'(bus.cursor_x), x);
        check_val({tag, "_y"}, int'(bus.cursor_y), y);
    endtask

    // Waits (bounded) for ready, offers one byte, returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (!bus.char_ready && waited < 6000) begin
            @(negedge proc_clk);
            waited++;
        end
        if (!bus.char_ready) check_val("send_ready_timeout", 0, 1);
        bus.char_valid = 1'b1;
        bus.char_in    = b;
        @(negedge proc_clk);
        bus.char_valid = 1'b0;
    endtask

    // Starting at the current negedge, expects n consecutive fill writes from start,
    // then char_ready exactly one cycle after the last one.
    task automatic run_clear(input int start, input int n, input string tag);
        int cnt = 0, bad = 0, last = -1, rdy_i = -1;
        bit done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            if (bus.ram_we) begin
                if (int'(bus.ram_addr) != start + cnt || bus.ram_data !== 8'h20 || bus.char_ready)
                    bad++;
                cnt++;
                last = i;
            end
            if (bus.char_ready) begin
                done  = 1'b1;
                rdy_i = i;
            end else begin
                @(negedge proc_clk);
            end
        end
        check_val({tag, "_done"}, int'(done), 1);
        check_val({tag, "_count"}, cnt, n);
        check_val({tag, "_seq_err"}, bad, 0);
        check_val({tag, "_ready_gap"}, rdy_i - last, 1);
    endtask

    initial begin
        int bad;
        rst            = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        repeat (3) @(negedge proc_clk);

        check_val("rst_we",    int'(bus.ram_we), 0);
        check_val("rst_addr",  int'(bus.ram_addr), 0);
        check_val("rst_data",  int'(bus.ram_data), 0);
        check_val("rst_ready", int'(bus.char_ready), 0);
        check_val("rst_busy",  int'(bus.busy), 1);
        check_pos("rst", 0, 0);

        rst = 1'b0;
        run_clear(0, 4800, "init_clr");
        check_val("init_busy_low", int'(bus.busy), 0);

        // Single printable at home
        send_byte(8'h41);
        check_val("a_we",   int'(bus.ram_we), 1);
        check_val("a_addr", int'(bus.ram_addr), 0);
        check_val("a_data", int'(bus.ram_data), 8'h41);
        check_pos("a", 1, 0);
        @(negedge proc_clk);
        check_val("a_pulse_len", int'(bus.ram_we), 0);

        // CR back to column 0, then fill row 0 to force a wrap
        send_byte(CH_CR);
        check_val("cr0_nowrite", int'(bus.ram_we), 0);
        check_pos("cr0", 0, 0);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            send_byte(8'h61 + 8'(i % 26));
            if (!bus.ram_we || int'(bus.ram_addr) != i || int'(bus.ram_data) != 8'h61 + (i % 26))
                bad++;
        end
        check_val("row0_fill_err", bad, 0);
        check_val("row0_last_busy", int'(bus.char_ready), 0);
        @(negedge proc_clk);
        run_clear(80, 80, "row1_clr");
        check_pos("wrap", 0, 1);

        // Walk down to the last row with LFs
        for (int r = 2; r < 60; r++) begin
            send_byte(CH_LF);
            run_clear(r * 80, 80, "lf_clr");
        end
        check_pos("row59", 0, 59);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h78);
            if (!bus.ram_we || int'(bus.ram_addr) != 4720 + i || bus.ram_data !== 8'h78) bad++;
        end
        check_val("row59_fill_err", bad, 0);
        check_pos("pre_wrap", 5, 59);

        send_byte(CH_LF);
        check_pos("lf_wrap", 5, 0);
        run_clear(0, 80, "wrap_clr");
        send_byte(CH_CR);
        check_val("cr_nowrite", int'(bus.ram_we), 0);
        check_pos("cr", 0, 0);

        // Backspace at (3,2) and at column 0
        send_byte(CH_LF);
        run_clear(80, 80, "bs_row1_clr");
        send_byte(CH_LF);
        run_clear(160, 80, "bs_row2_clr");
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
        check_pos("pre_bs", 3, 2);
        send_byte(CH_BS);
        check_val("bs_we",   int'(bus.ram_we), 1);
        check_val("bs_addr", int'(bus.ram_addr), 162);
        check_val("bs_data", int'(bus.ram_data), 8'h20);
        check_pos("bs", 2, 2);
        send_byte(CH_CR);
        send_byte(CH_BS);
        check_val("bs0_nowrite", int'(bus.ram_we), 0);
        check_pos("bs0", 0, 2);
        send_byte(8'h01);
        check_val("other_nowrite", int'(bus.ram_we), 0);
        check_pos("other", 0, 2);

        // FF clears screen; a byte offered during the clear must wait and then land at (0,0)
        send_byte(CH_FF);
        check_pos("ff", 0, 0);
        bus.char_valid = 1'b1;
        bus.char_in    = 8'h5A;
        run_clear(0, 4800, "ff_clr");
        @(negedge proc_clk);
        bus.char_valid = 1'b0;
        check_val("held_we",   int'(bus.ram_we), 1);
        check_val("held_addr", int'(bus.ram_addr), 0);
        check_val("held_data", int'(bus.ram_data), 8'h5A);
        check_pos("held", 1, 0);

        // Asynchronous reset in the middle of a row clear
        send_byte(CH_LF);
        repeat (3) @(negedge proc_clk);
        check_val("pre_rst_we", int'(bus.ram_we), 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_we",    int'(bus.ram_we), 0);
        check_val("arst_ready", int'(bus.char_ready), 0);
        check_val("arst_addr",  int'(bus.ram_addr), 0);
        check_pos("arst", 0, 0);
        @(negedge proc_clk);
        rst = 1'b0;
        run_clear(0, 4800, "rst_clr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
